// File: rtl/pulse_stretch_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretch_pkg
// Shared definitions for the pulse-stretch register stage:
//   - state_e       : per-channel stretcher state (IDLE / STRETCH)
//   - DEF_*         : default parameter values for the top level
//   - eff_len()     : effective stretch length, a programmed length of zero
//                     behaves as one cycle
// -----------------------------------------------------------------------------
package pulse_stretch_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        STRETCH = 1'b1
    } state_e;

    localparam int DEF_CFG_BUS_W   = 512;
    localparam int DEF_PULSE_BUS_W = 16;
    localparam int DEF_CFG_W       = 16;
    localparam int DEF_N_CH        = 4;
    localparam int DEF_LEN_W       = 8;
    localparam int DEF_RETRIG      = 0;

    // Zero is promoted to one so a trigger always yields a visible pulse.
    function automatic logic [31:0] eff_len(input logic [31:0] len);
        logic [31:0] res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// -----------------------------------------------------------------------------
// pulse_stretch_ch
// One stretcher channel: registers the request bit, detects a rising edge and
// stretches it into a pulse of eff_len(len) cycles.
// Ports:
//   CLK1      in   clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   pulse_in  in   request bit
//   len       in   registered stretch length (sampled only at trigger)
//   pulse_out out  stretched pulse (registered)
// -----------------------------------------------------------------------------
module pulse_stretch_ch
    import pulse_stretch_pkg::*;
#(
    parameter int LEN_W  = DEF_LEN_W,
    parameter bit RETRIG = 1'b0
) (
    input  logic             CLK1,
    input  logic             RESET_N,
    input  logic             pulse_in,
    input  logic [LEN_W-1:0] len,
    output logic             pulse_out
);

    state_e           state_r;
    logic [LEN_W-1:0] cnt_r;
    logic             pq_r;
    logic             pp_r;
    logic             armed_r;
    logic             edge_s;
    logic [LEN_W-1:0] reload_s;

    // Edge qualification and counter reload value (length captured at trigger).
    // armed_r blocks a request that is still high when reset releases: a new
    // pulse always needs the input to be seen low first.
    always_comb begin
        edge_s   = pq_r & ~pp_r & armed_r;
        reload_s = LEN_W'(eff_len(32'(len)) - 32'd1);
    end

    // Request input register pair and arming flag.
    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            pq_r    <= 1'b0;
            pp_r    <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            pq_r    <= pulse_in;
            pp_r    <= pq_r;
            armed_r <= armed_r | ~pulse_in;
        end
    end

    // Stretcher FSM with down-counter and registered pulse output.
    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= IDLE;
            cnt_r     <= {LEN_W{1'b0}};
            pulse_out <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (edge_s) begin
                        cnt_r     <= reload_s;
                        state_r   <= STRETCH;
                        pulse_out <= 1'b1;
                    end
                end
                STRETCH: begin
                    if (RETRIG && edge_s) begin
                        cnt_r <= reload_s;
                    end else if (cnt_r != {LEN_W{1'b0}}) begin
                        cnt_r <= cnt_r - LEN_W'(32'd1);
                    end else begin
                        state_r   <= IDLE;
                        pulse_out <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= {LEN_W{1'b0}};
                    pulse_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pulse_stretch_regs.sv
// -----------------------------------------------------------------------------
// pulse_stretch_regs
// Registers the config word and per-channel stretch lengths from the wide
// configuration bus, flags config-word changes and stretches rising edges on
// the pulse-request bus, one pulse_stretch_ch per channel.
// Ports:
//   CLK1          in   sole clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   CONFIG_REG    in   config bus: [CFG_W-1:0] config word, then N_CH
//                      LEN_W-bit length fields
//   PULSE_REG     in   pulse-request bus, bit ch drives channel ch
//   config_reg_0  out  registered config word
//   cfg_changed   out  one-cycle strobe after config_reg_0 changes value
//   pulse_out     out  stretched pulses
//   busy          out  channel active (same as pulse_out)
// -----------------------------------------------------------------------------
module pulse_stretch_regs
    import pulse_stretch_pkg::*;
#(
    parameter int CFG_BUS_W   = DEF_CFG_BUS_W,
    parameter int PULSE_BUS_W = DEF_PULSE_BUS_W,
    parameter int CFG_W       = DEF_CFG_W,
    parameter int N_CH        = DEF_N_CH,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int RETRIG      = DEF_RETRIG
) (
    input  logic                   CLK1,
    input  logic                   RESET_N,
    input  logic [CFG_BUS_W-1:0]   CONFIG_REG,
    input  logic [PULSE_BUS_W-1:0] PULSE_REG,
    output logic [CFG_W-1:0]       config_reg_0,
    output logic                   cfg_changed,
    output logic [N_CH-1:0]        pulse_out,
    output logic [N_CH-1:0]        busy
);

    if ((CFG_W + N_CH * LEN_W > CFG_BUS_W) || (N_CH > PULSE_BUS_W) || (N_CH < 1)) begin : g_bad_params
        $error("pulse_stretch_regs: length fields exceed CONFIG_REG or N_CH out of range");
    end

    logic [CFG_W-1:0]            cfg_prev_r;
    logic [N_CH-1:0][LEN_W-1:0]  len_r;
    logic [N_CH-1:0]             pulse_s;
    logic                        unused_s;

    // Bus bits beyond the decoded fields are intentionally ignored.
    assign unused_s = ^{CONFIG_REG, PULSE_REG};

    // Config word register and change detector; previous value starts at zero
    // so a nonzero first load counts as a change.
    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            config_reg_0 <= {CFG_W{1'b0}};
            cfg_prev_r   <= {CFG_W{1'b0}};
            cfg_changed  <= 1'b0;
        end else begin
            config_reg_0 <= CONFIG_REG[CFG_W-1:0];
            cfg_prev_r   <= config_reg_0;
            cfg_changed  <= (config_reg_0 != cfg_prev_r);
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        // Per-channel length register, reloaded every cycle.
        always_ff @(posedge CLK1 or negedge RESET_N) begin
            if (!RESET_N) begin
                len_r[ch] <= {LEN_W{1'b0}};
            end else begin
                len_r[ch] <= CONFIG_REG[CFG_W + ch*LEN_W +: LEN_W];
            end
        end

        pulse_stretch_ch #(
            .LEN_W  (LEN_W),
            .RETRIG (RETRIG != 0)
        ) u_ch (
            .CLK1      (CLK1),
            .RESET_N   (RESET_N),
            .pulse_in  (PULSE_REG[ch]),
            .len       (len_r[ch]),
            .pulse_out (pulse_s[ch])
        );
    end

    assign pulse_out = pulse_s;
    assign busy      = pulse_s;

endmodule

// File: tb/tb_pulse_stretch_regs.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch_regs
// Drives two instances (no retrigger / retrigger) from the same buses.
// A reference model predicts every output for the coming edge; predictions
// are queued at drive time and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_pulse_stretch_regs;

    localparam int CFG_BUS_W   = 512;
    localparam int PULSE_BUS_W = 16;
    localparam int CFG_W       = 16;
    localparam int N_CH        = 4;
    localparam int LEN_W       = 8;

    logic                   CLK1       = 1'b0;
    logic                   RESET_N    = 1'b0;
    logic [CFG_BUS_W-1:0]   CONFIG_REG = '0;
    logic [PULSE_BUS_W-1:0] PULSE_REG  = '0;

    logic [CFG_W-1:0] cfg0_s, cfg1_s;
    logic             chg0_s, chg1_s;
    logic [N_CH-1:0]  p0_s, b0_s, p1_s, b1_s;

    pulse_stretch_regs #(
        .CFG_BUS_W(CFG_BUS_W), .PULSE_BUS_W(PULSE_BUS_W), .CFG_W(CFG_W),
        .N_CH(N_CH), .LEN_W(LEN_W), .RETRIG(0)
    ) dut0 (
        .CLK1(CLK1), .RESET_N(RESET_N), .CONFIG_REG(CONFIG_REG), .PULSE_REG(PULSE_REG),
        .config_reg_0(cfg0_s), .cfg_changed(chg0_s), .pulse_out(p0_s), .busy(b0_s)
    );

    pulse_stretch_regs #(
        .CFG_BUS_W(CFG_BUS_W), .PULSE_BUS_W(PULSE_BUS_W), .CFG_W(CFG_W),
        .N_CH(N_CH), .LEN_W(LEN_W), .RETRIG(1)
    ) dut1 (
        .CLK1(CLK1), .RESET_N(RESET_N), .CONFIG_REG(CONFIG_REG), .PULSE_REG(PULSE_REG),
        .config_reg_0(cfg1_s), .cfg_changed(chg1_s), .pulse_out(p1_s), .busy(b1_s)
    );

    always #5 CLK1 = ~CLK1;

    typedef struct packed {
        logic [CFG_W-1:0] cfg;
        logic             chg;
        logic [N_CH-1:0]  p0;
        logic [N_CH-1:0]  p1;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    int         m_rem0[N_CH];
    int         m_rem1[N_CH];
    int         m_len[N_CH];
    logic       m_pq[N_CH];
    logic       m_pp[N_CH];
    logic       m_arm[N_CH];
    logic [CFG_W-1:0] m_cfg, m_prev;
    logic       m_chg;

    // observed statistics
    int hi0[N_CH], hi1[N_CH], rise0[N_CH], rise1[N_CH];
    logic [N_CH-1:0] last0, last1;
    int first0;
    int n_chg;
    int raise_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_rem0[c] = 0; m_rem1[c] = 0; m_len[c] = 0;
            m_pq[c] = 1'b0; m_pp[c] = 1'b0; m_arm[c] = 1'b0;
        end
        m_cfg = '0; m_prev = '0; m_chg = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        logic e;
        int   el;
        for (int c = 0; c < N_CH; c++) begin
            e  = m_pq[c] & ~m_pp[c] & m_arm[c];
            el = (m_len[c] == 0) ? 1 : m_len[c];
            if (m_rem0[c] == 0) m_rem0[c] = e ? el : 0;
            else                m_rem0[c] = m_rem0[c] - 1;
            if (e)                  m_rem1[c] = el;
            else if (m_rem1[c] > 0) m_rem1[c] = m_rem1[c] - 1;
            m_arm[c] = m_arm[c] | ~PULSE_REG[c];
            m_pp[c]  = m_pq[c];
            m_pq[c]  = PULSE_REG[c];
            m_len[c] = int'(CONFIG_REG[CFG_W + c*LEN_W +: LEN_W]);
        end
        m_chg  = (m_cfg != m_prev);
        m_prev = m_cfg;
        m_cfg  = CONFIG_REG[CFG_W-1:0];
    endtask

    task automatic clr_stats();
        for (int c = 0; c < N_CH; c++) begin
            hi0[c] = 0; hi1[c] = 0; rise0[c] = 0; rise1[c] = 0;
        end
        last0 = '0; last1 = '0; first0 = -1; n_chg = 0;
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.cfg = m_cfg;
        e.chg = m_chg;
        for (int c = 0; c < N_CH; c++) begin
            e.p0[c] = (m_rem0[c] != 0);
            e.p1[c] = (m_rem1[c] != 0);
        end
        exp_q.push_back(e);
        @(posedge CLK1);
        @(negedge CLK1);
        cyc++;
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cfg0", cfg0_s, e.cfg);
            chk("cfg1", cfg1_s, e.cfg);
            chk("chg0", chg0_s, e.chg);
            chk("chg1", chg1_s, e.chg);
            chk("pulse0", p0_s, e.p0);
            chk("busy0", b0_s, e.p0);
            chk("pulse1", p1_s, e.p1);
            chk("busy1", b1_s, e.p1);
        end
        for (int c = 0; c < N_CH; c++) begin
            if (p0_s[c]) hi0[c]++;
            if (p1_s[c]) hi1[c]++;
            if (p0_s[c] && !last0[c]) rise0[c]++;
            if (p1_s[c] && !last1[c]) rise1[c]++;
        end
        if (p0_s[0] && !last0[0] && first0 < 0) first0 = cyc;
        if (chg0_s) n_chg++;
        last0 = p0_s;
        last1 = p1_s;
    endtask

    task automatic set_len(input int c, input logic [LEN_W-1:0] v);
        CONFIG_REG[CFG_W + c*LEN_W +: LEN_W] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        clr_stats();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK1);
        chk("rst_cfg", cfg0_s, 0);
        chk("rst_chg", chg0_s, 0);
        chk("rst_pulse0", p0_s, 0);
        chk("rst_busy1", b1_s, 0);
        RESET_N = 1'b1;
        repeat (2) tick();

        // config word change, then rewrite with the same value
        clr_stats();
        CONFIG_REG[CFG_W-1:0] = 16'hA5A5;
        repeat (3) tick();
        CONFIG_REG[CFG_W-1:0] = 16'hA5A5;
        repeat (3) tick();
        chk("cfg_strobes", n_chg, 1);

        // ch0 len=5, level held high for 20 cycles
        set_len(0, 8'd5);
        repeat (2) tick();
        clr_stats();
        PULSE_REG[0] = 1'b1;
        raise_cyc = cyc + 1;
        repeat (20) tick();
        PULSE_REG[0] = 1'b0;
        repeat (5) tick();
        chk("len5_high", hi0[0], 5);
        chk("len5_rises", rise0[0], 1);
        chk("len5_latency", first0 - raise_cyc, 1);
        chk("len5_high_rt", hi1[0], 5);

        // len=0 on ch1, len=255 on ch2
        set_len(1, 8'd0);
        set_len(2, 8'd255);
        repeat (2) tick();
        clr_stats();
        PULSE_REG[2:1] = 2'b11;
        tick();
        PULSE_REG[2:1] = 2'b00;
        repeat (262) tick();
        chk("len0_high", hi0[1], 1);
        chk("len255_high", hi0[2], 255);
        chk("len255_rises", rise0[2], 1);

        // second edge three cycles into an 8-cycle pulse
        set_len(0, 8'd8);
        repeat (2) tick();
        clr_stats();
        PULSE_REG[0] = 1'b1;
        repeat (2) tick();
        PULSE_REG[0] = 1'b0;
        tick();
        PULSE_REG[0] = 1'b1;
        repeat (20) tick();
        PULSE_REG[0] = 1'b0;
        repeat (3) tick();
        chk("noretrig_high", hi0[0], 8);
        chk("noretrig_rises", rise0[0], 1);
        chk("retrig_high", hi1[0], 11);
        chk("retrig_rises", rise1[0], 1);

        // simultaneous edges on all channels, lengths 1..4
        for (int c = 0; c < N_CH; c++) set_len(c, LEN_W'(c + 1));
        repeat (2) tick();
        clr_stats();
        PULSE_REG[3:0] = 4'hF;
        tick();
        PULSE_REG[3:0] = 4'h0;
        repeat (8) tick();
        for (int c = 0; c < N_CH; c++) chk("allch_high", hi0[c], c + 1);

        // reset during a 10-cycle pulse
        set_len(0, 8'd10);
        repeat (2) tick();
        clr_stats();
        PULSE_REG[0] = 1'b1;
        repeat (5) tick();
        chk("pre_rst_high", hi0[0], 4);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_drop0", p0_s[0], 0);
        chk("async_drop1", p1_s[0], 0);
        model_reset();
        repeat (2) @(negedge CLK1);
        RESET_N = 1'b1;
        clr_stats();
        repeat (6) tick();
        chk("no_retrig_after_rst", hi0[0], 0);
        PULSE_REG[0] = 1'b0;
        tick();
        PULSE_REG[0] = 1'b1;
        repeat (14) tick();
        PULSE_REG[0] = 1'b0;
        repeat (2) tick();
        chk("post_rst_high", hi0[0], 10);
        chk("post_rst_rises", rise0[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
